// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS control slice: state encoding,
// opcodes, ALU operation codes and datapath mux encodings.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_R_EXEC   = 4'd2,
    S_R_WB     = 4'd3,
    S_I_EXEC   = 4'd4,
    S_I_WB     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Dispatch out of DECODE; anything unrecognised traps.
  function automatic state_t decodeNext(input logic [5:0] opcode);
    state_t nxt;
    case (opcode)
      OP_RTYPE:                 nxt = S_R_EXEC;
      OP_LW, OP_SW:             nxt = S_MEM_ADDR;
      OP_BEQ, OP_BNE:           nxt = S_BRANCH;
      OP_ADDI, OP_ORI, OP_ANDI: nxt = S_I_EXEC;
      OP_J:                     nxt = S_JUMP;
      OP_JAL:                   nxt = S_JAL;
      default:                  nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

  function automatic logic [2:0] immAluOp(input logic [5:0] opcode);
    logic [2:0] aop;
    case (opcode)
      OP_ORI:  aop = ALU_OR;
      OP_ANDI: aop = ALU_AND;
      default: aop = ALU_ADD;
    endcase
    return aop;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles and flags the cycle that reaches LIMIT.
// LIMIT = 0 disables expiry entirely.
module mem_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic countEn,
  output logic expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count;

  // Expiry fires on the LIMIT-th wait cycle itself, so the FSM can leave right after it.
  assign expired = (LIMIT != 0) && countEn && (count == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (countEn && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencer driving PC/IR/regfile/ALU/memory strobes per phase.
// Optional performance counters are built when MC_CTRL_PERF_EN is defined.
module multicycle_control
  import mips_mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic [1:0] pc_source,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       trap,
  output logic [3:0] state_out
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instr_count
`endif
);

  state_t state, nextState;
  logic   memState, memWait, timeoutHit;

  assign memState  = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign memWait   = memState && !mem_ready;
  assign state_out = state;

  mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) uTimer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!memWait),
    .countEn (memWait),
    .expired (timeoutHit)
  );

  always_comb begin
    nextState = state;
    case (state)
      S_FETCH:    if (mem_ready) nextState = S_DECODE;
                  else if (timeoutHit) nextState = S_TRAP;
      S_DECODE:   nextState = decodeNext(op);
      S_R_EXEC:   nextState = S_R_WB;
      S_I_EXEC:   nextState = S_I_WB;
      S_MEM_ADDR: nextState = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) nextState = S_MEM_WB;
                  else if (timeoutHit) nextState = S_TRAP;
      S_MEM_WR:   if (mem_ready) nextState = S_FETCH;
                  else if (timeoutHit) nextState = S_TRAP;
      S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_JAL:
                  nextState = S_FETCH;
      S_TRAP:     nextState = S_TRAP;
      default:    nextState = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      trap  <= 1'b0;
    end else begin
      state <= nextState;
      if (nextState == S_TRAP) trap <= 1'b1;
    end
  end

  // Strobes are Moore from state except the FETCH handshake; reset silences everything.
  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = PCSRC_ALU;
    reg_write     = 1'b0;
    reg_dst       = REGDST_RT;
    mem_to_reg    = M2R_ALUOUT;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:   alu_src_b = SRCB_IMMSH;
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_RTYPE;
        end
        S_R_WB: begin
          reg_dst   = REGDST_RD;
          reg_write = 1'b1;
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = immAluOp(op);
        end
        S_I_WB:     reg_write = 1'b1;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
        end
        S_MEM_WB: begin
          mem_to_reg = M2R_MDR;
          reg_write  = 1'b1;
        end
        S_MEM_WR: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          branch_ne     = (op == OP_BNE);
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCSRC_JUMP;
        end
        S_JAL: begin
          pc_write   = 1'b1;
          pc_source  = PCSRC_JUMP;
          reg_dst    = REGDST_RA;
          mem_to_reg = M2R_PC;
          reg_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MC_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (state != S_TRAP) cycle_count <= cycle_count + 1'b1;
      if (state != S_FETCH && nextState == S_FETCH) instr_count <= instr_count + 1'b1;
    end
  end
`else
  // Default build carries no performance counters.
`endif

endmodule
